// File: rtl/frame_reader.sv
// Streams frame-SRAM words out as bytes, least-significant byte first, over a
// valid/ready link. Reads addresses 0..last_addr once per rising edge of read_kick.
module frame_reader #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_kick,
  input  logic [17:0] last_addr,
  output logic        s1_RE,
  output logic [17:0] s1_Addr,
  input  logic [31:0] s1_RD,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        read_busy,
  output logic        read_done
);

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SEND} state_t;

  state_t      state, state_nxt;
  logic        kick_d;
  logic [17:0] end_addr, end_addr_nxt;
  logic [17:0] addr, addr_nxt;
  logic [31:0] word, word_nxt;
  logic [1:0]  byte_idx, byte_idx_nxt;
  logic [2:0]  lat_cnt, lat_cnt_nxt;
  logic        re_nxt;
  logic [17:0] s1_addr_nxt;
  logic [7:0]  tx_data_nxt;
  logic        tx_valid_nxt;
  logic        busy_nxt;
  logic        done_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      kick_d    <= 1'b0;
      end_addr  <= '0;
      addr      <= '0;
      word      <= '0;
      byte_idx  <= '0;
      lat_cnt   <= '0;
      s1_RE     <= 1'b1;
      s1_Addr   <= '1;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      read_busy <= 1'b0;
      read_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      kick_d    <= read_kick;
      end_addr  <= end_addr_nxt;
      addr      <= addr_nxt;
      word      <= word_nxt;
      byte_idx  <= byte_idx_nxt;
      lat_cnt   <= lat_cnt_nxt;
      s1_RE     <= re_nxt;
      s1_Addr   <= s1_addr_nxt;
      tx_data   <= tx_data_nxt;
      tx_valid  <= tx_valid_nxt;
      read_busy <= busy_nxt;
      read_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    end_addr_nxt = end_addr;
    addr_nxt     = addr;
    word_nxt     = word;
    byte_idx_nxt = byte_idx;
    lat_cnt_nxt  = lat_cnt;
    re_nxt       = s1_RE;
    s1_addr_nxt  = s1_Addr;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    busy_nxt     = read_busy;
    done_nxt     = read_done;

    unique case (state)
      IDLE: begin
        if (read_kick && !kick_d) begin
          end_addr_nxt = last_addr;
          addr_nxt     = '0;
          re_nxt       = 1'b0;
          s1_addr_nxt  = '0;
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
          lat_cnt_nxt  = '0;
          state_nxt    = WAIT;
        end
      end
      // RE was already pulled low on the final accept so the next read starts
      // with no dead cycle; ISSUE is the RE-low cycle and counts as latency step 0.
      ISSUE: begin
        re_nxt      = 1'b1;
        lat_cnt_nxt = 3'd1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        re_nxt = 1'b1;
        if (lat_cnt == LAT) begin
          word_nxt     = s1_RD;
          tx_data_nxt  = s1_RD[7:0];
          tx_valid_nxt = 1'b1;
          byte_idx_nxt = '0;
          state_nxt    = SEND;
        end else begin
          lat_cnt_nxt = lat_cnt + 3'd1;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (byte_idx == 2'd3) begin
            tx_valid_nxt = 1'b0;
            if (addr == end_addr) begin
              busy_nxt    = 1'b0;
              done_nxt    = 1'b1;
              s1_addr_nxt = '1;
              state_nxt   = IDLE;
            end else begin
              addr_nxt    = addr + 18'd1;
              re_nxt      = 1'b0;
              s1_addr_nxt = addr + 18'd1;
              state_nxt   = ISSUE;
            end
          end else begin
            byte_idx_nxt = byte_idx + 2'd1;
            tx_data_nxt  = word[{byte_idx_nxt, 3'b000} +: 8];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: SRAM latency models, byte scoreboard, table of
// transfers plus reset, back-pressure and RD_LATENCY=3 sequences.
module tb_frame_reader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        read_kick = 1'b0;
  logic [17:0] last_addr = '0;
  logic        s1_RE;
  logic [17:0] s1_Addr;
  logic [31:0] s1_RD;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        read_busy, read_done;

  logic        b_kick = 1'b0;
  logic [17:0] b_last_addr = '0;
  logic        b_RE;
  logic [17:0] b_Addr;
  logic [31:0] b_RD;
  logic [7:0]  b_tx_data;
  logic        b_tx_valid;
  logic        b_tx_ready;
  logic        b_busy, b_done;
  assign b_tx_ready = 1'b1;

  frame_reader #(.RD_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .read_kick(read_kick), .last_addr(last_addr),
    .s1_RE(s1_RE), .s1_Addr(s1_Addr), .s1_RD(s1_RD), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .read_busy(read_busy), .read_done(read_done)
  );

  frame_reader #(.RD_LATENCY(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .read_kick(b_kick), .last_addr(b_last_addr),
    .s1_RE(b_RE), .s1_Addr(b_Addr), .s1_RD(b_RD), .tx_data(b_tx_data),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .read_busy(b_busy), .read_done(b_done)
  );

  // SRAM models: data valid only in the cycle before the capture edge
  logic [31:0] mem [8];
  logic        pa_v = 1'b0;
  logic [17:0] pa_a = '0;
  always @(posedge clk) begin
    pa_v <= !s1_RE;
    pa_a <= s1_Addr;
  end
  assign s1_RD = pa_v ? mem[pa_a[2:0]] : 32'hDEADBEEF;

  logic [2:0]  pb_v = '0;
  logic [17:0] pb_a [3];
  always @(posedge clk) begin
    pb_v    <= {pb_v[1:0], !b_RE};
    pb_a[0] <= b_Addr;
    pb_a[1] <= pb_a[0];
    pb_a[2] <= pb_a[1];
  end
  assign b_RD = pb_v[2] ? mem[pb_a[2][2:0]] : 32'hDEADBEEF;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic extra_byte(input string name, input logic [7:0] d);
    checks++;
    errors++;
    $display("FAIL %s: got %02h expected no byte", name, d);
  endtask

  // scoreboard / monitor for the RD_LATENCY=1 instance
  logic [7:0]  sbq[$];
  int          re_cyc_q[$];
  logic [17:0] re_addr_q[$];
  int          nacc = 0;
  int          last_acc_cyc = 0;
  bit          re_prev = 1'b0;
  bit          re_long = 1'b0;
  bit          stall_req = 1'b0;
  int          stall_cnt = 0;
  logic [7:0]  held = '0;

  always @(negedge clk) begin
    if (stall_cnt > 0) begin
      chk("stall_data", 32'(tx_data), 32'(held));
      chk("stall_valid", 32'(tx_valid), 32'd1);
      stall_cnt--;
    end else if (stall_req && tx_valid && nacc == 6) begin
      stall_req = 1'b0;
      held      = tx_data;
      stall_cnt = 5;
    end
    tx_ready = (stall_cnt == 0);
    if (tx_valid && tx_ready) begin
      if (sbq.size() == 0) extra_byte("extra_byte", tx_data);
      else chk("byte", 32'(tx_data), 32'(sbq.pop_front()));
      nacc++;
      last_acc_cyc = cyc;
    end
    if (!s1_RE) begin
      re_cyc_q.push_back(cyc);
      re_addr_q.push_back(s1_Addr);
      if (re_prev) re_long = 1'b1;
    end
    re_prev = !s1_RE;
  end

  // monitor for the RD_LATENCY=3 instance
  logic [7:0] bq[$];
  int         b_re_cyc[$];
  int         b_nacc = 0;
  int         b_first_valid = -1;

  always @(negedge clk) begin
    if (b_tx_valid && b_first_valid < 0) b_first_valid = cyc;
    if (b_tx_valid && b_tx_ready) begin
      if (bq.size() == 0) extra_byte("b_extra_byte", b_tx_data);
      else chk("b_byte", 32'(b_tx_data), 32'(bq.pop_front()));
      b_nacc++;
    end
    if (!b_RE) b_re_cyc.push_back(cyc);
  end

  typedef struct {
    logic [17:0] la;
    logic [31:0] word0;
    logic [31:0] base;
    bit          stall;
    int          exp_bytes;
    int          exp_pulses;
    int          gap2;
  } vec_t;

  task automatic push_words(input int la);
    logic [31:0] wd;
    for (int w = 0; w <= la; w++) begin
      wd = mem[w];
      for (int b = 0; b < 4; b++) sbq.push_back(wd[8*b +: 8]);
    end
  endtask

  task automatic run_xfer(input logic [17:0] la, input bit stall, input int exp_bytes,
                          input int exp_pulses, input int gap2);
    int done_cyc;
    bit seen;
    sbq.delete();
    re_cyc_q.delete();
    re_addr_q.delete();
    nacc    = 0;
    re_long = 1'b0;
    done_cyc = 0;
    push_words(int'(la));
    stall_req = stall;
    last_addr = la;
    @(posedge clk);
    #1 read_kick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("kick_re", 32'(s1_RE), 32'd0);
    chk("kick_addr", 32'(s1_Addr), 32'd0);
    chk("kick_busy", 32'(read_busy), 32'd1);
    chk("kick_done_clr", 32'(read_done), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (i == 2) begin
        read_kick = 1'b0;
        last_addr = ~la;
      end
      if (i == 4) read_kick = 1'b1;
      if (read_done) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_timing", done_cyc, last_acc_cyc + 1);
    chk("byte_count", nacc, exp_bytes);
    chk("sb_empty", sbq.size(), 0);
    chk("addr_park", 32'(s1_Addr), 32'h3ffff);
    chk("busy_fall", 32'(read_busy), 32'd0);
    chk("valid_low", 32'(tx_valid), 32'd0);
    repeat (10) @(negedge clk);
    chk("re_pulses", re_cyc_q.size(), exp_pulses);
    chk("re_width", 32'(re_long), 32'd0);
    chk("done_sticky", 32'(read_done), 32'd1);
    for (int p = 0; p < re_cyc_q.size(); p++) begin
      chk("re_addr", 32'(re_addr_q[p]), p);
      if (p > 0) chk("re_period", re_cyc_q[p] - re_cyc_q[p-1], (p == 2) ? gap2 : 6);
    end
    read_kick = 1'b0;
    last_addr = la;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{18'd0, 32'h44332211, 32'hA0A0A0A0, 1'b0, 4,  1, 6};
    vecs[1] = '{18'd3, 32'hA0A0A0A0, 32'hA0A0A0A0, 1'b0, 16, 4, 6};
    vecs[2] = '{18'd3, 32'h12345678, 32'h12345678, 1'b1, 16, 4, 11};
    vecs[3] = '{18'd5, 32'h0F1E2D3C, 32'h0F1E2D3C, 1'b0, 24, 6, 6};
    for (int n = 0; n < 8; n++) mem[n] = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_re", 32'(s1_RE), 32'd1);
    chk("rst_addr", 32'(s1_Addr), 32'h3ffff);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(read_busy), 32'd0);
    chk("rst_done", 32'(read_done), 32'd0);
    chk("rst_b_re", 32'(b_RE), 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      mem[0] = vecs[v].word0;
      for (int n = 1; n < 8; n++) mem[n] = vecs[v].base + 32'(n);
      run_xfer(vecs[v].la, vecs[v].stall, vecs[v].exp_bytes, vecs[v].exp_pulses, vecs[v].gap2);
    end

    // asynchronous reset while sending word 2
    begin
      bit reached;
      sbq.delete();
      nacc = 0;
      push_words(3);
      last_addr = 18'd3;
      @(posedge clk);
      #1 read_kick = 1'b1;
      reached = 1'b0;
      for (int i = 0; i < 200 && !reached; i++) begin
        @(negedge clk);
        if (nacc >= 9) reached = 1'b1;
      end
      chk("mid_reached", 32'(reached), 32'd1);
      read_kick = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("mrst_re", 32'(s1_RE), 32'd1);
      chk("mrst_addr", 32'(s1_Addr), 32'h3ffff);
      chk("mrst_data", 32'(tx_data), 32'd0);
      chk("mrst_valid", 32'(tx_valid), 32'd0);
      chk("mrst_busy", 32'(read_busy), 32'd0);
      chk("mrst_done", 32'(read_done), 32'd0);
      sbq.delete();
      re_cyc_q.delete();
      re_addr_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_no_re", re_cyc_q.size(), 0);
      chk("post_rst_re", 32'(s1_RE), 32'd1);
      chk("post_rst_busy", 32'(read_busy), 32'd0);
      chk("post_rst_done", 32'(read_done), 32'd0);
    end

    run_xfer(18'd1, 1'b0, 8, 2, 6);

    // RD_LATENCY=3 instance
    begin
      bit seen;
      logic [31:0] wd;
      for (int w = 0; w < 2; w++) begin
        wd = mem[w];
        for (int b = 0; b < 4; b++) bq.push_back(wd[8*b +: 8]);
      end
      b_last_addr = 18'd1;
      @(posedge clk);
      #1 b_kick = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (b_done) seen = 1'b1;
      end
      chk("b_done", 32'(seen), 32'd1);
      chk("b_bytes", b_nacc, 8);
      chk("b_sb_empty", bq.size(), 0);
      chk("b_re_pulses", b_re_cyc.size(), 2);
      if (b_re_cyc.size() >= 2) begin
        chk("b_first_gap", b_first_valid - b_re_cyc[0], 4);
        chk("b_period", b_re_cyc[1] - b_re_cyc[0], 8);
      end
      b_kick = 1'b0;
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
